// File: rtl/lc4_ooo_pkg.sv
// Shared sizing for the LC4 out-of-order rename path: architectural and
// physical register counts, free-list depth and the physical tag type.
package lc4_ooo_pkg;

    localparam int N_ARCH   = 8;
    localparam int TAG_W    = 4;
    localparam int N_PHYS   = 1 << TAG_W;
    localparam int FL_DEPTH = N_PHYS - N_ARCH;
    // A depth of 1 still needs a one-bit pointer register.
    localparam int FL_PTR_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

    typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/lc4_fl_ptr.sv
// Modulo-DEPTH circular-buffer pointer. Load takes priority over increment;
// the wrap is explicit so DEPTH need not be a power of two.
module lc4_fl_ptr
    import lc4_ooo_pkg::*;
#(
    parameter int DEPTH = FL_DEPTH,
    parameter int PTR_W = FL_PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gwe,
    input  logic             inc,
    input  logic             load,
    input  logic [PTR_W-1:0] load_val,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (gwe) begin
            if (!rst) begin
                ptr <= '0;
            end else if (load) begin
                ptr <= load_val;
            end else if (inc) begin
                ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/lc4_free_list.sv
// Physical-register free list: circular buffer with a speculative allocation
// head and a retire head; flush rewinds the speculative head in one cycle.
module lc4_free_list
    import lc4_ooo_pkg::*;
#(
    parameter int n = N_ARCH,
    parameter int w = TAG_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         gwe,
    input  logic         alloc_req,
    output logic         alloc_valid,
    output logic [w-1:0] alloc_tag,
    input  logic         commit,
    input  logic [w-1:0] commit_tag,
    input  logic         flush,
    output logic [w:0]   free_count,
    output logic         err
);

    localparam int DEPTH = (1 << w) - n;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [w:0] DEPTH_C = (w + 1)'(DEPTH);

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [w-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] spec_head;
    logic [PTR_W-1:0] ret_head;
    logic [PTR_W-1:0] ret_upd;
    logic [w:0]       inflight;
    logic             do_alloc;
    logic             do_commit;
    logic             bad_alloc;
    logic             bad_commit;

    assign alloc_valid = (inflight != DEPTH_C);
    assign alloc_tag   = mem[spec_head];
    assign free_count  = DEPTH_C - inflight;

    // A flush squashes any allocation in the same cycle without flagging it.
    assign do_alloc   = alloc_req & alloc_valid & ~flush;
    assign bad_alloc  = alloc_req & ~alloc_valid & ~flush;
    assign do_commit  = commit & (inflight != '0);
    assign bad_commit = commit & (inflight == '0);

    // Flush rewinds to the retire head as it stands after this cycle's commit.
    assign ret_upd = do_commit ? wrap_inc(ret_head) : ret_head;

    lc4_fl_ptr #(
        .DEPTH    (DEPTH),
        .PTR_W    (PTR_W)
    ) u_spec (
        .clk      (clk),
        .rst      (rst),
        .gwe      (gwe),
        .inc      (do_alloc),
        .load     (flush),
        .load_val (ret_upd),
        .ptr      (spec_head)
    );

    lc4_fl_ptr #(
        .DEPTH    (DEPTH),
        .PTR_W    (PTR_W)
    ) u_ret (
        .clk      (clk),
        .rst      (rst),
        .gwe      (gwe),
        .inc      (do_commit),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (ret_head)
    );

    always_ff @(posedge clk) begin
        if (gwe) begin
            if (!rst) begin
                inflight <= '0;
                err      <= 1'b0;
            end else begin
                if (flush) begin
                    inflight <= '0;
                end else if (do_alloc && !do_commit) begin
                    inflight <= inflight + (w + 1)'(1);
                end else if (do_commit && !do_alloc) begin
                    inflight <= inflight - (w + 1)'(1);
                end
                if (bad_alloc || bad_commit) begin
                    err <= 1'b1;
                end
            end
        end
    end

    // The retire slot always belongs to an in-flight entry, so writing it
    // never clobbers a tag that is still free.
    always_ff @(posedge clk) begin
        if (gwe) begin
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= w'(n + i);
                end
            end else if (do_commit) begin
                mem[ret_head] <= commit_tag;
            end
        end
    end

endmodule
